cpu_sequenciador: RTL and testbench

Multi-cycle control sequencer for the next-generation CPU. It replaces the single-cycle fetch/execute timing with an explicit phase FSM. It owns the program counter and the ROM fetch wait (ROM_LATENCY), and adds real handshakes for IN and OUT plus a resumable HALT. It drives one-cycle write strobes into the existing register bank, RAM and instruction register.

---
 rtl/cpu_sequenciador.sv | 191 +++++++++++++++++++
 tb/tb_cpu_sequenciador.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequenciador.sv
// Multi-cycle phase sequencer: owns pc, ROM fetch wait, IN/OUT handshakes, HALT.
// Optional: define SEQ_TRAP_EN to trap illegal opcodes instead of executing a NOP.
module cpu_sequenciador #(
   parameter int ADDR_WIDTH  = 7,
   parameter int ROM_LATENCY = 1,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [5:0]             opcode,
   input  logic                   zero,
   input  logic [ADDR_WIDTH-1:0]  jump_target,
   input  logic [ADDR_WIDTH-1:0]  jr_target,
   input  logic                   in_valid,
   input  logic                   out_ready,
   input  logic                   resume,
   output logic [ADDR_WIDTH-1:0]  pc,
   output logic                   ir_load,
   output logic                   reg_write,
   output logic                   mem_write,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic                   halted,
   output logic [2:0]             state,
   output logic [COUNT_WIDTH-1:0] instr_count
);

   localparam int FW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_IO     = 3'd5,
      S_HALTED = 3'd6,
      S_TRAP   = 3'd7
   } state_t;

   localparam logic [5:0] OP_ALUR  = 6'h00;
   localparam logic [5:0] OP_ALUI  = 6'h01;
   localparam logic [5:0] OP_LOAD  = 6'h02;
   localparam logic [5:0] OP_STORE = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h06;
   localparam logic [5:0] OP_JR    = 6'h07;
   localparam logic [5:0] OP_IN    = 6'h08;
   localparam logic [5:0] OP_OUT   = 6'h09;
   localparam logic [5:0] OP_MOV   = 6'h0A;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   state_t                 state_q, state_d;
   logic [FW-1:0]          fcnt_q, fcnt_d;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [5:0]             op_q, op_d;
   logic [ADDR_WIDTH-1:0]  pc_inc;
   logic                   fetch_last;
   logic                   to_fetch;
   logic                   retire;

   assign pc_inc     = pc_q + ADDR_WIDTH'(1);
   assign fetch_last = (fcnt_q == FW'(ROM_LATENCY - 1));

   always_comb begin
      state_d  = state_q;
      fcnt_d   = fcnt_q;
      pc_d     = pc_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      to_fetch = 1'b0;
      retire   = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            if (fetch_last) begin
               fcnt_d  = '0;
               state_d = S_DECODE;
            end else begin
               fcnt_d = fcnt_q + FW'(1);
            end
         end
         S_DECODE: begin
            op_d = opcode;
            case (opcode)
               OP_ALUR, OP_ALUI, OP_MOV, OP_LOAD, OP_STORE,
               OP_BEQ, OP_BNE, OP_J, OP_JR: state_d = S_EXEC;
               OP_IN, OP_OUT:               state_d = S_IO;
               OP_HALT: begin
                  state_d = S_HALTED;
                  retire  = 1'b1;
               end
`ifdef SEQ_TRAP_EN
               default: state_d = S_TRAP;
`else
               default: state_d = S_EXEC;
`endif
            endcase
         end
         S_EXEC: begin
            case (op_q)
               OP_ALUR, OP_ALUI, OP_MOV: state_d = S_WB;
               OP_LOAD, OP_STORE:        state_d = S_MEM;
               OP_BEQ: begin
                  to_fetch = 1'b1;
                  pc_d     = zero ? jump_target : pc_inc;
               end
               OP_BNE: begin
                  to_fetch = 1'b1;
                  pc_d     = zero ? pc_inc : jump_target;
               end
               OP_J: begin
                  to_fetch = 1'b1;
                  pc_d     = jump_target;
               end
               OP_JR: begin
                  to_fetch = 1'b1;
                  pc_d     = jr_target;
               end
               // illegal opcodes retire here as a NOP
               default: begin
                  to_fetch = 1'b1;
                  pc_d     = pc_inc;
               end
            endcase
         end
         S_MEM: begin
            if (op_q == OP_STORE) begin
               to_fetch = 1'b1;
               pc_d     = pc_inc;
            end else begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            to_fetch = 1'b1;
            pc_d     = pc_inc;
         end
         S_IO: begin
            if (op_q == OP_IN) begin
               if (in_valid) state_d = S_WB;
            end else if (out_ready) begin
               to_fetch = 1'b1;
               pc_d     = pc_inc;
            end
         end
         S_HALTED: begin
            // already counted on entry
            if (resume) begin
               state_d = S_FETCH;
               pc_d    = pc_inc;
            end
         end
         S_TRAP: state_d = S_TRAP;
      endcase
      if (to_fetch) begin
         state_d = S_FETCH;
         retire  = 1'b1;
      end
      if (retire) cnt_d = cnt_q + COUNT_WIDTH'(1);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         fcnt_q  <= '0;
         pc_q    <= '0;
         cnt_q   <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   // ir_load is gated so no strobe is seen while reset is held
   assign ir_load     = (state_q == S_FETCH) && fetch_last && reset;
   assign reg_write   = (state_q == S_WB);
   assign mem_write   = (state_q == S_MEM) && (op_q == OP_STORE);
   assign in_ready    = (state_q == S_IO) && (op_q == OP_IN);
   assign out_valid   = (state_q == S_IO) && (op_q == OP_OUT);
   assign halted      = (state_q == S_HALTED);
   assign state       = state_q;
   assign pc          = pc_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_sequenciador.sv
// Bench for cpu_sequenciador: phase-list model per instruction plus literal checks.
// Build with SEQ_TRAP_EN defined to exercise the trap variant.
module tb_cpu_sequenciador;

   localparam int AW = 7;
   localparam int RL = 1;
   localparam int CW = 16;

   localparam int P_F  = 0;
   localparam int P_D  = 1;
   localparam int P_E  = 2;
   localparam int P_M  = 3;
   localparam int P_W  = 4;
   localparam int P_IO = 5;
   localparam int P_H  = 6;
   localparam int P_T  = 7;

   logic          clock = 1'b0;
   logic          reset;
   logic [5:0]    opcode;
   logic          zero;
   logic [AW-1:0] jump_target;
   logic [AW-1:0] jr_target;
   logic          in_valid;
   logic          out_ready;
   logic          resume;
   logic [AW-1:0] pc;
   logic          ir_load;
   logic          reg_write;
   logic          mem_write;
   logic          in_ready;
   logic          out_valid;
   logic          halted;
   logic [2:0]    state;
   logic [CW-1:0] instr_count;

   cpu_sequenciador #(
      .ADDR_WIDTH (AW),
      .ROM_LATENCY(RL),
      .COUNT_WIDTH(CW)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .opcode     (opcode),
      .zero       (zero),
      .jump_target(jump_target),
      .jr_target  (jr_target),
      .in_valid   (in_valid),
      .out_ready  (out_ready),
      .resume     (resume),
      .pc         (pc),
      .ir_load    (ir_load),
      .reg_write  (reg_write),
      .mem_write  (mem_write),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .halted     (halted),
      .state      (state),
      .instr_count(instr_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [2:0]    st;
      logic [AW-1:0] pc;
      logic          il, rw, mw, ir, ov, h;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          ce;
   int            total = 0;
   int            bad = 0;
   logic [AW-1:0] m_pc;
   logic [CW-1:0] m_cnt;

   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         ce = exp_q.pop_front();
         total++;
         if ({state, pc, ir_load, reg_write, mem_write, in_ready,
              out_valid, halted, instr_count} !==
             {ce.st, ce.pc, ce.il, ce.rw, ce.mw, ce.ir,
              ce.ov, ce.h, ce.cnt}) begin
            bad++;
            $display("FAIL cycle t=%0t got st=%0d pc=%h il%b rw%b mw%b ir%b ov%b h%b cnt=%0d want st=%0d pc=%h il%b rw%b mw%b ir%b ov%b h%b cnt=%0d",
               $time, state, pc, ir_load, reg_write, mem_write, in_ready,
               out_valid, halted, instr_count, ce.st, ce.pc, ce.il, ce.rw,
               ce.mw, ce.ir, ce.ov, ce.h, ce.cnt);
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] got,
                        input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   task automatic run_instr(input logic [5:0] op, input logic z,
                            input logic [AW-1:0] jt, input logic [AW-1:0] jrt,
                            input int w, input int abort_at);
      int   ph[$];
      bit   trap;
      bit   wait_ph;
      bit   hs;
      exp_t e;
      trap = 0;
      for (int i = 0; i < RL; i++) ph.push_back(P_F);
      ph.push_back(P_D);
      case (op)
         6'h00, 6'h01, 6'h0A: begin ph.push_back(P_E); ph.push_back(P_W); end
         6'h02: begin ph.push_back(P_E); ph.push_back(P_M); ph.push_back(P_W); end
         6'h03: begin ph.push_back(P_E); ph.push_back(P_M); end
         6'h04, 6'h05, 6'h06, 6'h07: ph.push_back(P_E);
         6'h08: begin
            for (int i = 0; i <= w; i++) ph.push_back(P_IO);
            ph.push_back(P_W);
         end
         6'h09: for (int i = 0; i <= w; i++) ph.push_back(P_IO);
         6'h3F: for (int i = 0; i <= w; i++) ph.push_back(P_H);
         default: begin
`ifdef SEQ_TRAP_EN
            trap = 1;
            for (int i = 0; i < w; i++) ph.push_back(P_T);
`else
            ph.push_back(P_E);
`endif
         end
      endcase
      for (int i = 0; i < ph.size(); i++) begin
         wait_ph = (ph[i] == P_IO) || (ph[i] == P_H);
         hs = wait_ph && ((i + 1 >= ph.size()) || (ph[i+1] != ph[i]));
         opcode      = op;
         zero        = z;
         jump_target = jt;
         jr_target   = jrt;
         in_valid    = wait_ph ? (hs && op == 6'h08) : 1'b1;
         out_ready   = wait_ph ? (hs && op == 6'h09) : 1'b1;
         resume      = wait_ph ? (hs && op == 6'h3F) : 1'b1;
         e.st  = 3'(ph[i]);
         e.pc  = m_pc;
         e.il  = (ph[i] == P_F) && (i == RL - 1);
         e.rw  = (ph[i] == P_W);
         e.mw  = (ph[i] == P_M) && (op == 6'h03);
         e.ir  = (ph[i] == P_IO) && (op == 6'h08);
         e.ov  = (ph[i] == P_IO) && (op == 6'h09);
         e.h   = (ph[i] == P_H);
         e.cnt = (ph[i] == P_H) ? m_cnt + 1'b1 : m_cnt;
         exp_q.push_back(e);
         if (i == abort_at) begin
            @(negedge clock);
            #2;
            reset = 1'b0;
            #1;
            check("rst_mem_write", 32'(mem_write), 32'd0);
            check("rst_pc", 32'(pc), 32'd0);
            check("rst_state", 32'(state), 32'd0);
            check("rst_count", 32'(instr_count), 32'd0);
            check("rst_ir_load", 32'(ir_load), 32'd0);
            m_pc  = '0;
            m_cnt = '0;
            @(posedge clock);
            #1;
            reset = 1'b1;
            return;
         end
         @(posedge clock);
         #1;
      end
      if (!trap) begin
         case (op)
            6'h04:   m_pc = z ? jt : m_pc + 1'b1;
            6'h05:   m_pc = z ? m_pc + 1'b1 : jt;
            6'h06:   m_pc = jt;
            6'h07:   m_pc = jrt;
            default: m_pc = m_pc + 1'b1;
         endcase
         m_cnt = m_cnt + 1'b1;
      end
   endtask

   initial begin
      reset = 1'b0;
      opcode = '0;
      zero = 1'b0;
      jump_target = '0;
      jr_target = '0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      resume = 1'b0;
      m_pc = '0;
      m_cnt = '0;
      #3;
      check("init_pc", 32'(pc), 32'd0);
      check("init_state", 32'(state), 32'd0);
      check("init_count", 32'(instr_count), 32'd0);
      check("init_strobes", 32'({ir_load, reg_write, mem_write, in_ready,
                                 out_valid, halted}), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;

      run_instr(6'h06, 1'b0, 7'h05, 7'h00, 0, -1);
      run_instr(6'h00, 1'b0, 7'h00, 7'h00, 0, -1);
      check("alu_pc", 32'(pc), 32'h06);
      check("alu_cnt", 32'(instr_count), 32'd2);
      run_instr(6'h05, 1'b0, 7'h12, 7'h00, 0, -1);
      check("bne_taken_pc", 32'(pc), 32'h12);
      run_instr(6'h05, 1'b1, 7'h30, 7'h00, 0, -1);
      check("bne_not_pc", 32'(pc), 32'h13);
      run_instr(6'h04, 1'b1, 7'h20, 7'h00, 0, -1);
      run_instr(6'h04, 1'b0, 7'h50, 7'h00, 0, -1);
      check("beq_pc", 32'(pc), 32'h21);
      run_instr(6'h02, 1'b0, 7'h00, 7'h00, 0, -1);
      run_instr(6'h03, 1'b0, 7'h00, 7'h00, 0, -1);
      run_instr(6'h0A, 1'b0, 7'h00, 7'h00, 0, -1);
      run_instr(6'h01, 1'b1, 7'h00, 7'h00, 0, -1);
      run_instr(6'h07, 1'b0, 7'h11, 7'h40, 0, -1);
      check("jr_pc", 32'(pc), 32'h40);
      run_instr(6'h08, 1'b0, 7'h00, 7'h00, 10, -1);
      run_instr(6'h09, 1'b0, 7'h00, 7'h00, 4, -1);
      check("io_pc", 32'(pc), 32'h42);
      run_instr(6'h06, 1'b0, 7'h7F, 7'h00, 0, -1);
      run_instr(6'h3F, 1'b0, 7'h00, 7'h00, 3, -1);
      check("halt_wrap_pc", 32'(pc), 32'h00);
      check("halt_cnt", 32'(instr_count), 32'd15);

      run_instr(6'h03, 1'b0, 7'h00, 7'h00, 0, 3);

`ifdef SEQ_TRAP_EN
      run_instr(6'h2A, 1'b0, 7'h00, 7'h00, 5, -1);
      check("trap_state", 32'(state), 32'd7);
      check("trap_pc", 32'(pc), 32'h00);
      check("trap_cnt", 32'(instr_count), 32'd0);
      reset = 1'b0;
      #1;
      check("trap_rst_state", 32'(state), 32'd0);
      #1;
      reset = 1'b1;
`else
      run_instr(6'h2A, 1'b0, 7'h00, 7'h00, 0, -1);
      check("nop_pc", 32'(pc), 32'h01);
      check("nop_cnt", 32'(instr_count), 32'd1);
`endif
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
